fifo_ctrl: RTL and testbench



---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_ctrl_if.sv | 49 ++++
 rtl/fifo_ns_logic.sv | 75 +++++++
 rtl/fifo_ctrl.sv | 92 +++++++++
 tb/tb_fifo_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fifo_pkg
// Purpose  : Shared widths and operation-state encodings for the FIFO
//            control front-end.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int ADDR_WIDTH_DEFAULT = 3;

  localparam int STATE_WIDTH = 3;
  typedef logic [STATE_WIDTH-1:0] state_t;

  // Operation-state encodings; the registered state directly drives the flags
  localparam state_t INIT     = 3'b000;
  localparam state_t NO_OP    = 3'b001;
  localparam state_t WRITE    = 3'b010;
  localparam state_t WR_ERROR = 3'b011;
  localparam state_t READ     = 3'b100;
  localparam state_t RD_ERROR = 3'b101;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fifo_ctrl_if
// Purpose  : Push/pop request bus plus the register-file write/read port of
//            the FIFO controller. "slave" is the controller's view, "master"
//            is the view of the user logic and register file around it.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
interface fifo_ctrl_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) ();

  // request side
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] d_in;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  full;
  logic                  empty;
  logic                  wr_ack;
  logic                  wr_err;
  logic                  rd_ack;
  logic                  rd_err;
  logic [ADDR_WIDTH:0]   data_count;

  // register-file side
  logic                  rf_we;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic [ADDR_WIDTH-1:0] rf_raddr;
  logic [DATA_WIDTH-1:0] rf_rdata;

  modport slave (
    input  wr_en, rd_en, d_in, rf_rdata,
    output d_out, full, empty, wr_ack, wr_err, rd_ack, rd_err, data_count,
           rf_we, rf_waddr, rf_wdata, rf_raddr
  );

  modport master (
    output wr_en, rd_en, d_in, rf_rdata,
    input  d_out, full, empty, wr_ack, wr_err, rd_ack, rd_err, data_count,
           rf_we, rf_waddr, rf_wdata, rf_raddr
  );

endinterface : fifo_ctrl_if
`default_nettype wire

// File: rtl/fifo_ns_logic.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fifo_ns_logic
// Purpose  : Purely combinational next-state, next-pointer and next-count
//            calculation for the FIFO controller.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module fifo_ns_logic
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input  logic                  i_wr_en,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH:0]   i_count,
  input  logic [ADDR_WIDTH-1:0] i_head,
  input  logic [ADDR_WIDTH-1:0] i_tail,
  output state_t                o_next_state,
  output logic                  o_push,
  output logic                  o_pop,
  output logic [ADDR_WIDTH-1:0] o_next_head,
  output logic [ADDR_WIDTH-1:0] o_next_tail,
  output logic [ADDR_WIDTH:0]   o_next_count
);

  localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

  logic w_full;
  logic w_empty;

  // full/empty come only from the occupancy count, never from the pointers
  assign w_full  = (i_count == c_depth);
  assign w_empty = (i_count == '0);

  // Next state is independent of the current state; simultaneous requests
  // are both dropped so the count can never move in two directions at once.
  always_comb begin
    o_next_state = NO_OP;
    o_push       = 1'b0;
    o_pop        = 1'b0;
    case ({i_wr_en, i_rd_en})
      2'b10: begin
        if (w_full) begin
          o_next_state = WR_ERROR;
        end else begin
          o_next_state = WRITE;
          o_push       = 1'b1;
        end
      end
      2'b01: begin
        if (w_empty) begin
          o_next_state = RD_ERROR;
        end else begin
          o_next_state = READ;
          o_pop        = 1'b1;
        end
      end
      default: o_next_state = NO_OP;
    endcase
  end

  // Pointers wrap naturally at ADDR_WIDTH bits; rejected requests move nothing
  always_comb begin
    o_next_head  = o_pop  ? i_head + ADDR_WIDTH'(1) : i_head;
    o_next_tail  = o_push ? i_tail + ADDR_WIDTH'(1) : i_tail;
    o_next_count = i_count;
    if (o_push) begin
      o_next_count = i_count + (ADDR_WIDTH+1)'(1);
    end else if (o_pop) begin
      o_next_count = i_count - (ADDR_WIDTH+1)'(1);
    end
  end

endmodule : fifo_ns_logic
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fifo_ctrl
// Purpose  : Control and datapath front-end of an 8x32 FIFO. Holds the head
//            and tail pointers, occupancy count, operation-state register and
//            the registered pop data; drives an external register file.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  fifo_ctrl_if.slave  bus
);

  localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_head;
  logic [ADDR_WIDTH-1:0] r_tail;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_d_out;

  state_t                w_next_state;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_next_head;
  logic [ADDR_WIDTH-1:0] w_next_tail;
  logic [ADDR_WIDTH:0]   w_next_count;

  fifo_ns_logic #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ns_logic (
    .i_wr_en      (bus.wr_en),
    .i_rd_en      (bus.rd_en),
    .i_count      (r_count),
    .i_head       (r_head),
    .i_tail       (r_tail),
    .o_next_state (w_next_state),
    .o_push       (w_push),
    .o_pop        (w_pop),
    .o_next_head  (w_next_head),
    .o_next_tail  (w_next_tail),
    .o_next_count (w_next_count)
  );

  // State, pointer and count registers; reset clears them without a clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= INIT;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_head  <= w_next_head;
      r_tail  <= w_next_tail;
      r_count <= w_next_count;
    end
  end

  // Pop data is captured from the register file only on an accepted pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d_out <= '0;
    end else if (w_pop) begin
      r_d_out <= bus.rf_rdata;
    end
  end

  // Output decode: flags from the registered state, rf port from pointers
  always_comb begin
    bus.d_out      = r_d_out;
    bus.data_count = r_count;
    bus.full       = (r_count == c_depth);
    bus.empty      = (r_count == '0);
    bus.wr_ack     = (r_state == WRITE);
    bus.wr_err     = (r_state == WR_ERROR);
    bus.rd_ack     = (r_state == READ);
    bus.rd_err     = (r_state == RD_ERROR);
    bus.rf_we      = w_push;
    bus.rf_waddr   = r_tail;
    bus.rf_wdata   = bus.d_in;
    bus.rf_raddr   = r_head;
  end

endmodule : fifo_ctrl
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_fifo_ctrl
// Purpose  : Directed, table-driven bench for fifo_ctrl with a behavioural
//            8x32 register file hung off the rf_* port.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_fifo_ctrl;

  logic clk;
  logic reset;

  fifo_ctrl_if bus ();

  fifo_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // behavioural register file: synchronous write, combinational read
  logic [31:0] mem [8];
  assign bus.rf_rdata = mem[bus.rf_raddr];
  always @(posedge clk) begin
    if (bus.rf_we) mem[bus.rf_waddr] <= bus.rf_wdata;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] din;
    logic        exp_we;
    logic [2:0]  exp_waddr;
    logic [3:0]  exp_count;
    logic        exp_full;
    logic        exp_empty;
    logic [3:0]  exp_flags;   // {wr_ack, wr_err, rd_ack, rd_err}
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic wr, input logic rd, input logic [31:0] din,
                              input logic we, input logic [2:0] waddr, input logic [3:0] cnt,
                              input logic full, input logic empty, input logic [3:0] flags,
                              input logic [31:0] dout);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din; v.exp_we = we; v.exp_waddr = waddr;
    v.exp_count = cnt; v.exp_full = full; v.exp_empty = empty;
    v.exp_flags = flags; v.exp_dout = dout;
    vq.push_back(v);
  endfunction

  function automatic logic [3:0] flags_now();
    return {bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err};
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    reset     = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.d_in  = 32'h0;

    // ---------------- vector table ----------------
    // fill with 0x11..0x88, tail 0..7
    for (int i = 0; i < 8; i++)
      add(1, 0, 32'h11 * (i + 1), 1, 3'(i), 4'(i + 1), (i == 7), 0, 4'b1000, 32'h0);
    // overflow push: rejected, tail already wrapped to 0
    add(1, 0, 32'h99, 0, 3'd0, 4'd8, 1, 0, 4'b0100, 32'h0);
    // drain: data back in order one edge after each request
    for (int i = 0; i < 8; i++)
      add(0, 1, 32'h0, 0, 3'd0, 4'(7 - i), 0, (i == 7), 4'b0010, 32'h11 * (i + 1));
    // underflow pop: rejected, d_out holds 0x88
    add(0, 1, 32'h0, 0, 3'd0, 4'd0, 0, 1, 4'b0001, 32'h88);
    add(0, 0, 32'h0, 0, 3'd0, 4'd0, 0, 1, 4'b0000, 32'h88);
    // wrap-around: push 6, pop 6, push 5 (tail 6,7,0,1,2), pop 5
    for (int i = 0; i < 6; i++)
      add(1, 0, 32'h100 + i, 1, 3'(i), 4'(i + 1), 0, 0, 4'b1000, 32'h88);
    for (int i = 0; i < 6; i++)
      add(0, 1, 32'h0, 0, 3'd6, 4'(5 - i), 0, (i == 5), 4'b0010, 32'h100 + i);
    for (int i = 0; i < 5; i++)
      add(1, 0, 32'h200 + i, 1, 3'((6 + i) % 8), 4'(i + 1), 0, 0, 4'b1000, 32'h105);
    for (int i = 0; i < 5; i++)
      add(0, 1, 32'h0, 0, 3'd3, 4'(4 - i), 0, (i == 4), 4'b0010, 32'h200 + i);
    // build count=3, then simultaneous push+pop is ignored
    for (int i = 0; i < 3; i++)
      add(1, 0, 32'h300 + i, 1, 3'(3 + i), 4'(i + 1), 0, 0, 4'b1000, 32'h204);
    add(1, 1, 32'hDEAD, 0, 3'd6, 4'd3, 0, 0, 4'b0000, 32'h204);
    add(1, 1, 32'hBEEF, 0, 3'd6, 4'd3, 0, 0, 4'b0000, 32'h204);

    // ---------------- reset then idle ----------------
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_count", bus.data_count, 0);
    chk("rst_dout", bus.d_out, 0);
    chk("rst_flags", flags_now(), 0);
    chk("rst_rf_we", bus.rf_we, 0);

    // ---------------- apply table ----------------
    foreach (vq[i]) begin
      bus.wr_en = vq[i].wr;
      bus.rd_en = vq[i].rd;
      bus.d_in  = vq[i].din;
      #1;
      chk($sformatf("v%0d_rf_we", i), bus.rf_we, vq[i].exp_we);
      chk($sformatf("v%0d_waddr", i), bus.rf_waddr, vq[i].exp_waddr);
      chk($sformatf("v%0d_wdata", i), bus.rf_wdata, vq[i].din);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_count", i), bus.data_count, vq[i].exp_count);
      chk($sformatf("v%0d_full_empty", i), {bus.full, bus.empty},
          {vq[i].exp_full, vq[i].exp_empty});
      chk($sformatf("v%0d_flags", i), flags_now(), vq[i].exp_flags);
      chk($sformatf("v%0d_dout", i), bus.d_out, vq[i].exp_dout);
    end

    // ---------------- asynchronous reset mid-burst ----------------
    bus.wr_en = 1'b1; bus.rd_en = 1'b0; bus.d_in = 32'h400;
    @(posedge clk);
    #1;
    chk("burst_count4", bus.data_count, 4);
    bus.d_in = 32'h401;
    #1;
    chk("burst_waddr7", bus.rf_waddr, 7);
    #1 reset = 1'b1;              // no clock edge until well after this
    #1;
    chk("arst_count", bus.data_count, 0);
    chk("arst_empty_full", {bus.empty, bus.full}, 2'b10);
    chk("arst_flags", flags_now(), 0);
    chk("arst_dout", bus.d_out, 0);
    chk("arst_ptrs", {bus.rf_waddr, bus.rf_raddr}, 0);
    #2 reset = 1'b0;
    bus.d_in = 32'h55;
    #1;
    chk("post_rst_waddr", bus.rf_waddr, 0);
    chk("post_rst_we", bus.rf_we, 1);
    @(posedge clk);
    #1;
    chk("post_rst_count", bus.data_count, 1);
    chk("post_rst_flags", flags_now(), 4'b1000);
    bus.wr_en = 1'b0; bus.rd_en = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_dout", bus.d_out, 32'h55);
    chk("post_rst_pop", {flags_now(), bus.empty}, 5'b00101);
    bus.rd_en = 1'b0;
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_fifo_ctrl
`default_nettype wire
